mlp_layer_seq: RTL and testbench

//  Sequences the 4-lane int8 MAC/activation engine over one fully connected MLP layer.
//  For each output neuron k it:
//  - issues one MAC job: data at in_base, weights at w_base + k*n_in, n_in bytes;
//  - waits for the engine's done;
//  - writes the 8-bit activation into output BRAM at byte k (big-endian lanes).

---
 rtl/mlp_pkg.sv | 30 +++
 rtl/mlp_addr_gen.sv | 37 +++
 rtl/mlp_layer_seq.sv | 142 ++++++++++++++
 tb/tb_mlp_layer_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared state encoding, default widths and byte-lane write helper for the
// MLP layer sequencer.
package mlp_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int SIZE_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] din;
  } lane_wr_t;

  // Big-endian lanes: lane 0 owns bits 31:24, lane 3 owns bits 7:0.
  function automatic lane_wr_t lane_sel(input logic [1:0] lane, input logic [7:0] val);
    lane_wr_t r;
    r.we  = 4'b1000 >> lane;
    r.din = {val, 24'h000000} >> {lane, 3'b000};
    return r;
  endfunction
endpackage

// File: rtl/mlp_addr_gen.sv
// Running weight-row pointer and output word/lane pointer for the layer
// sequencer; advances by addition only.
module mlp_addr_gen
  import mlp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [SIZE_W-1:0] n_in,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] out_word_addr,
  output logic [1:0]        lane
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr          <= '0;
      out_word_addr <= '0;
      lane          <= 2'd0;
    end else if (load) begin
      wptr          <= w_base;
      out_word_addr <= out_base;
      lane          <= 2'd0;
    end else if (step) begin
      wptr <= wptr + ADDR_W'(n_in);
      lane <= lane + 2'd1;
      if (lane == 2'd3) out_word_addr <= out_word_addr + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/mlp_layer_seq.sv
// Sequences the 4-lane int8 MAC engine over one fully connected layer and
// packs each neuron's activation into the output BRAM.
//   state | meaning
//   IDLE  | waiting for start
//   CHECK | validate latched config
//   ISSUE | first cycle of MAC request
//   WAIT  | request held until mad_done
//   WRITE | one-cycle BRAM byte write
//   NEXT  | advance neuron counter/pointers
//   FIN   | done pulse, busy low
module mlp_layer_seq
  import mlp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic              nnclk,
  input  logic              nnrst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [SIZE_W-1:0] n_in,
  input  logic [CNT_W-1:0]  n_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mad_req,
  output logic [ADDR_W-1:0] mad_data_addr,
  output logic [ADDR_W-1:0] mad_wt_addr,
  output logic [SIZE_W-1:0] mad_size,
  input  logic              mad_done,
  input  logic [7:0]        mad_result,
  output logic [ADDR_W-1:0] output_addr,
  output logic [31:0]       output_din,
  output logic              output_en,
  output logic [3:0]        output_we
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] in_base_q, w_base_q, out_base_q;
  logic [SIZE_W-1:0] n_in_q;
  logic [CNT_W-1:0]  n_out_q, k;
  logic [7:0]        result_q;
  logic              err_q, load, step, cfg_bad, last;
  logic [ADDR_W-1:0] wptr, out_word_addr;
  logic [1:0]        lane;
  lane_wr_t          lw;

  mlp_addr_gen #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) u_addr_gen (
    .clk           (nnclk),
    .rst_n         (nnrst_n),
    .load          (load),
    .step          (step),
    .w_base        (w_base_q),
    .out_base      (out_base_q),
    .n_in          (n_in_q),
    .wptr          (wptr),
    .out_word_addr (out_word_addr),
    .lane          (lane)
  );

  assign cfg_bad = (n_in_q == '0) || (n_in_q[1:0] != 2'b00) || (in_base_q[1:0] != 2'b00) ||
                   (w_base_q[1:0] != 2'b00) || (out_base_q[1:0] != 2'b00);
  assign last    = ((k + CNT_W'(1)) == n_out_q);

  always_ff @(posedge nnclk) begin
    if (!nnrst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_n = ST_CHECK;
      ST_CHECK: begin
        if (cfg_bad || (n_out_q == '0)) begin
          state_n = ST_FIN;
        end else begin
          state_n = ST_ISSUE;
          load    = 1'b1;
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT:  if (mad_done) state_n = ST_WRITE;
      ST_WRITE: state_n = ST_NEXT;
      ST_NEXT: begin
        step    = 1'b1;
        state_n = last ? ST_FIN : ST_ISSUE;
      end
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge nnclk) begin
    if (!nnrst_n) begin
      in_base_q  <= '0;
      w_base_q   <= '0;
      out_base_q <= '0;
      n_in_q     <= '0;
      n_out_q    <= '0;
      k          <= '0;
      result_q   <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        in_base_q  <= in_base;
        w_base_q   <= w_base;
        out_base_q <= out_base;
        n_in_q     <= n_in;
        n_out_q    <= n_out;
        err_q      <= 1'b0;
      end
      if (state == ST_CHECK) begin
        k <= '0;
        if (cfg_bad) err_q <= 1'b1;
      end
      if ((state == ST_WAIT) && mad_done) result_q <= mad_result;
      if (state == ST_NEXT) k <= k + CNT_W'(1);
    end
  end

  // Pointers and write bus are forced to zero outside their active states.
  assign busy          = (state != ST_IDLE) && (state != ST_FIN);
  assign done          = (state == ST_FIN);
  assign err           = err_q;
  assign mad_req       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign mad_data_addr = mad_req ? in_base_q : '0;
  assign mad_wt_addr   = mad_req ? wptr : '0;
  assign mad_size      = mad_req ? n_in_q : '0;

  assign lw          = lane_sel(lane, result_q);
  assign output_en   = (state == ST_WRITE);
  assign output_addr = output_en ? out_word_addr : '0;
  assign output_we   = output_en ? lw.we : 4'b0000;
  assign output_din  = output_en ? lw.din : 32'h0;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Directed bench for mlp_layer_seq with a behavioural MAC engine that
// returns k+0x10 for job k after a programmable latency.
module tb_mlp_layer_seq;
  logic        nnclk = 1'b0;
  logic        nnrst_n, start, mad_done;
  logic [31:0] in_base, w_base, out_base, n_in;
  logic [15:0] n_out;
  logic [7:0]  mad_result;
  logic        busy, done, err, mad_req, output_en;
  logic [31:0] mad_data_addr, mad_wt_addr, mad_size, output_addr, output_din;
  logic [3:0]  output_we;

  int n_chk = 0, n_pass = 0;
  int mac_lat [3];
  int mac_job = 0;
  int n_req = 0, n_wr = 0, stab_err = 0, en_err = 0, done_cnt = 0;
  logic [31:0] wt_q [16], dq [16], sq [16], wa_q [16], wd_q [16];
  logic [3:0]  we_q [16];
  logic [31:0] held_wt, held_d, held_s;
  bit prev_req = 0, prev_en = 0;

  always #5 nnclk = ~nnclk;

  mlp_layer_seq dut (
    .nnclk(nnclk), .nnrst_n(nnrst_n), .start(start),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .n_in(n_in), .n_out(n_out),
    .busy(busy), .done(done), .err(err),
    .mad_req(mad_req), .mad_data_addr(mad_data_addr), .mad_wt_addr(mad_wt_addr),
    .mad_size(mad_size), .mad_done(mad_done), .mad_result(mad_result),
    .output_addr(output_addr), .output_din(output_din),
    .output_en(output_en), .output_we(output_we)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // MAC model: done comes 1+lat negedges after the ISSUE cycle.
  initial begin
    int lat;
    mad_done = 1'b0;
    mad_result = 8'h00;
    forever begin
      @(negedge nnclk);
      if (mad_req) begin
        lat = mac_lat[mac_job % 3];
        repeat (lat + 1) @(negedge nnclk);
        mad_result = 8'h10 + 8'(mac_job);
        mad_done = 1'b1;
        @(negedge nnclk);
        mad_done = 1'b0;
        mac_job++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge nnclk);
      if (mad_req && !prev_req) begin
        if (n_req < 16) begin
          wt_q[n_req] = mad_wt_addr; dq[n_req] = mad_data_addr; sq[n_req] = mad_size;
        end
        held_wt = mad_wt_addr; held_d = mad_data_addr; held_s = mad_size;
        n_req++;
      end else if (mad_req && prev_req) begin
        if (mad_wt_addr !== held_wt || mad_data_addr !== held_d || mad_size !== held_s)
          stab_err++;
      end
      if (output_en) begin
        if (n_wr < 16) begin
          wa_q[n_wr] = output_addr; we_q[n_wr] = output_we; wd_q[n_wr] = output_din;
        end
        n_wr++;
      end
      if (output_en && prev_en) en_err++;
      if (done) done_cnt++;
      prev_req = mad_req;
      prev_en  = output_en;
    end
  end

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_req"}, mad_req, 0);
    check({pfx, "_daddr"}, mad_data_addr, 0);
    check({pfx, "_waddr"}, mad_wt_addr, 0);
    check({pfx, "_size"}, mad_size, 0);
    check({pfx, "_oen"}, output_en, 0);
    check({pfx, "_owe"}, output_we, 0);
    check({pfx, "_oaddr"}, output_addr, 0);
    check({pfx, "_odin"}, output_din, 0);
  endtask

  // mode 0: plain run, 1: start pulse with other config during job 1 WAIT,
  // 2: reset during WRITE of neuron 2.
  task automatic run_layer(input logic [31:0] ib, input logic [31:0] wb, input logic [31:0] ob,
                           input logic [31:0] ni, input logic [15:0] no, input int mode,
                           input logic exp_err, input int exp_cyc);
    int cyc, wseen, reqcyc, jobs;
    bit got, glitched;
    logic [31:0] e_wt, e_addr, e_din;
    logic [3:0]  e_we;
    @(negedge nnclk);
    n_req = 0; n_wr = 0; stab_err = 0; en_err = 0; done_cnt = 0; mac_job = 0;
    in_base = ib; w_base = wb; out_base = ob; n_in = ni; n_out = no;
    start = 1'b1;
    @(negedge nnclk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0; wseen = 0; reqcyc = 0; got = 0; glitched = 0;
    while (!got && cyc < 3000) begin
      @(negedge nnclk);
      cyc++;
      if (start) start = 1'b0;
      reqcyc = mad_req ? reqcyc + 1 : 0;
      if (done) begin
        got = 1;
        check("busy_low_at_done", busy, 0);
        check("err_at_done", err, exp_err);
      end
      if (mode == 1 && !glitched && mac_job == 1 && reqcyc == 2) begin
        glitched = 1;
        in_base = 32'hDEAD0000; w_base = 32'h0BAD0000; out_base = 32'h00000800;
        n_in = 32'd4; n_out = 16'd2;
        start = 1'b1;
      end
      if (output_en) wseen++;
      if (mode == 2 && output_en && wseen == 3) begin
        nnrst_n = 1'b0;
        @(negedge nnclk);
        check_idle_outputs("rst_mid");
        nnrst_n = 1'b1;
        repeat (50) @(negedge nnclk);
        check("rst_no_more_writes", n_wr, 3);
        check("rst_no_more_jobs", n_req, 3);
        check("rst_no_done", done_cnt, 0);
        check("rst_busy_low", busy, 0);
        return;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    check("layer_cycles", cyc, exp_cyc);
    @(negedge nnclk);
    jobs = exp_err ? 0 : int'(no);
    check("err_sticky", err, exp_err);
    check("job_count", n_req, jobs);
    check("write_count", n_wr, jobs);
    check("done_count", done_cnt, 1);
    check("req_stable", stab_err, 0);
    check("en_one_cycle", en_err, 0);
    for (int j = 0; j < jobs && j < 16 && j < n_wr && j < n_req; j++) begin
      e_wt   = wb + 32'(j) * ni;
      e_addr = ob + 32'((j / 4) * 4);
      e_we   = 4'b1000 >> (j % 4);
      e_din  = 32'(8'h10 + 8'(j)) << (8 * (3 - (j % 4)));
      check($sformatf("wt_addr%0d", j), wt_q[j], e_wt);
      check($sformatf("data_addr%0d", j), dq[j], ib);
      check($sformatf("size%0d", j), sq[j], ni);
      check($sformatf("out_addr%0d", j), wa_q[j], e_addr);
      check($sformatf("out_we%0d", j), we_q[j], e_we);
      check($sformatf("out_din%0d", j), wd_q[j], e_din);
    end
  endtask

  initial begin
    mac_lat[0] = 0; mac_lat[1] = 0; mac_lat[2] = 0;
    nnrst_n = 1'b0;
    start = 1'b1;
    in_base = 32'h100; w_base = 32'h200; out_base = 32'h400; n_in = 32'd8; n_out = 16'd5;
    repeat (3) @(negedge nnclk);
    check_idle_outputs("reset");
    start = 1'b0;
    nnrst_n = 1'b1;
    @(negedge nnclk);
    check("reset_beats_start", busy, 0);

    // Test 1: normal layer, 1 + 4*5 cycles to FIN
    run_layer(32'h100, 32'h200, 32'h400, 32'd8, 16'd5, 0, 1'b0, 21);

    // Test 2: MAC latency 0,1,37,0,1
    mac_lat[0] = 0; mac_lat[1] = 1; mac_lat[2] = 37;
    run_layer(32'h100, 32'h200, 32'h400, 32'd8, 16'd5, 0, 1'b0, 60);

    // Test 3: bad configurations and empty layer
    mac_lat[0] = 0; mac_lat[1] = 0; mac_lat[2] = 0;
    run_layer(32'h100, 32'h200, 32'h400, 32'd6, 16'd5, 0, 1'b1, 1);
    run_layer(32'h100, 32'h200, 32'h402, 32'd8, 16'd5, 0, 1'b1, 1);
    run_layer(32'h100, 32'h200, 32'h400, 32'd0, 16'd5, 0, 1'b1, 1);
    run_layer(32'h100, 32'h200, 32'h400, 32'd8, 16'd0, 0, 1'b0, 1);

    // Test 4: start during WAIT of job 1 is ignored
    mac_lat[0] = 3; mac_lat[1] = 3; mac_lat[2] = 3;
    run_layer(32'h100, 32'h200, 32'h400, 32'd8, 16'd5, 1, 1'b0, 36);

    // Test 5: reset during WRITE of neuron 2, then a clean rerun
    mac_lat[0] = 0; mac_lat[1] = 0; mac_lat[2] = 0;
    run_layer(32'h100, 32'h200, 32'h400, 32'd8, 16'd5, 2, 1'b0, 0);
    run_layer(32'h100, 32'h200, 32'h400, 32'd8, 16'd5, 0, 1'b0, 21);

    // Test 6: weight pointer wraps past 2^32
    run_layer(32'h100, 32'hFFFFFFF8, 32'h400, 32'd8, 16'd3, 0, 1'b0, 13);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
